rv32im_csr_regfile: RTL and testbench



---
 rtl/rv32im_csr_regfile_pkg.sv | 61 ++++++
 rtl/rv32im_csr_counter64.sv | 38 +++
 rtl/rv32im_csr_regfile.sv | 145 ++++++++++++++
 tb/tb_rv32im_csr_regfile.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/rv32im_csr_regfile_pkg.sv
// Shared definitions for the RV32IM machine-mode CSR file: default data and
// address widths, CSR address map, privilege encodings, mstatus field
// positions and the per-register writable / fixed-value masks.
package rv32im_csr_regfile_pkg;

  localparam int API_XLEN  = 32;
  localparam int CSR_WIDTH = 12;

  // Machine information (constant)
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // Machine trap setup / handling
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;

  // Machine counters and their user-level read-only shadows
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  // Privilege encodings
  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  // mstatus field positions
  localparam int MSTATUS_MIE_BIT   = 3;
  localparam int MSTATUS_MPIE_BIT  = 7;
  localparam int MSTATUS_MPP_LO    = 11;
  localparam int MSTATUS_MPP_HI    = 12;

  // Writable masks and hardwired values
  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;  // MIE, MPIE
  localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;  // MPP = M
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;  // MSIE, MTIE, MEIE
  localparam logic [31:0] ALIGN4_WMASK  = 32'hFFFF_FFFC;  // mtvec, mepc
  localparam logic [31:0] MISA_VALUE    = 32'h4000_1100;  // RV32, I, M

  // Apply a writable mask and force the hardwired bits.
  function automatic logic [31:0] masked_write(input logic [31:0] data,
                                               input logic [31:0] wmask,
                                               input logic [31:0] fixed);
    masked_write = (data & wmask) | (fixed & ~wmask);
  endfunction

endpackage

// File: rtl/rv32im_csr_counter64.sv
// 64-bit counter built from two XLEN halves.
// Ports: clk_i, rst_n_i (sync, active-low), inc_en_i (count enable),
//        wr_lo_i / wr_hi_i (load low / high half from wr_data_i),
//        count_o (current value).
// A write to either half suppresses that edge's increment for the whole
// counter; the unwritten half holds.
module rv32im_csr_counter64 #(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              inc_en_i,
  input  logic              wr_lo_i,
  input  logic              wr_hi_i,
  input  logic [XLEN-1:0]   wr_data_i,
  output logic [2*XLEN-1:0] count_o
);

  logic [2*XLEN-1:0] count_r;

  // Counter state: reset, half loads, then increment
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count_r <= {(2*XLEN){1'b0}};
    end else if (wr_lo_i) begin
      count_r <= {count_r[2*XLEN-1:XLEN], wr_data_i};
    end else if (wr_hi_i) begin
      count_r <= {wr_data_i, count_r[XLEN-1:0]};
    end else if (inc_en_i) begin
      count_r <= count_r + {{(2*XLEN-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count_o = count_r;

endmodule

// File: rtl/rv32im_csr_regfile.sv
// Machine-mode CSR file for the RV32IM core.
// Ports: clk_i, rst_n_i (sync, active-low), csr_addr_i, val_csr_i (write data),
//        csr_write_en_i (commit on next edge), csr_read_en_i,
//        val_csr_o (combinational read data, 0 when read disabled),
//        csr_status_o (live mstatus), priviledge_mode_o (always M).
module rv32im_csr_regfile #(
  parameter int API_XLEN  = rv32im_csr_regfile_pkg::API_XLEN,
  parameter int CSR_WIDTH = rv32im_csr_regfile_pkg::CSR_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [CSR_WIDTH-1:0] csr_addr_i,
  input  logic [API_XLEN-1:0]  val_csr_i,
  input  logic                 csr_write_en_i,
  input  logic                 csr_read_en_i,
  output logic [API_XLEN-1:0]  val_csr_o,
  output logic [API_XLEN-1:0]  csr_status_o,
  output logic [1:0]           priviledge_mode_o
);

  import rv32im_csr_regfile_pkg::*;

  logic [API_XLEN-1:0] mstatus_r;
  logic [API_XLEN-1:0] mie_r;
  logic [API_XLEN-1:0] mtvec_r;
  logic [API_XLEN-1:0] mscratch_r;
  logic [API_XLEN-1:0] mepc_r;
  logic [API_XLEN-1:0] mcause_r;
  logic [API_XLEN-1:0] mtval_r;

  logic [2*API_XLEN-1:0] mcycle_s;
  logic [2*API_XLEN-1:0] minstret_s;

  logic wr_ok_s;
  logic we_mstatus_s, we_mie_s, we_mtvec_s, we_mscratch_s;
  logic we_mepc_s, we_mcause_s, we_mtval_s;
  logic we_mcycle_s, we_mcycleh_s, we_minstret_s, we_minstreth_s;

  logic [API_XLEN-1:0] rdata_s;

  // Top two address bits 2'b11 mark the read-only CSR space
  assign wr_ok_s = csr_write_en_i && (csr_addr_i[CSR_WIDTH-1 -: 2] != 2'b11);

  // Write strobe decode; unimplemented and constant CSRs get no strobe
  always_comb begin
    we_mstatus_s   = 1'b0;
    we_mie_s       = 1'b0;
    we_mtvec_s     = 1'b0;
    we_mscratch_s  = 1'b0;
    we_mepc_s      = 1'b0;
    we_mcause_s    = 1'b0;
    we_mtval_s     = 1'b0;
    we_mcycle_s    = 1'b0;
    we_mcycleh_s   = 1'b0;
    we_minstret_s  = 1'b0;
    we_minstreth_s = 1'b0;
    if (wr_ok_s) begin
      case (csr_addr_i)
        CSR_MSTATUS:   we_mstatus_s   = 1'b1;
        CSR_MIE:       we_mie_s       = 1'b1;
        CSR_MTVEC:     we_mtvec_s     = 1'b1;
        CSR_MSCRATCH:  we_mscratch_s  = 1'b1;
        CSR_MEPC:      we_mepc_s      = 1'b1;
        CSR_MCAUSE:    we_mcause_s    = 1'b1;
        CSR_MTVAL:     we_mtval_s     = 1'b1;
        CSR_MCYCLE:    we_mcycle_s    = 1'b1;
        CSR_MCYCLEH:   we_mcycleh_s   = 1'b1;
        CSR_MINSTRET:  we_minstret_s  = 1'b1;
        CSR_MINSTRETH: we_minstreth_s = 1'b1;
        default:       we_mstatus_s   = 1'b0;
      endcase
    end else begin
      we_mstatus_s = 1'b0;
    end
  end

  // Trap/status register state with per-register masking
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mstatus_r  <= MSTATUS_FIXED;
      mie_r      <= 32'h0000_0000;
      mtvec_r    <= 32'h0000_0000;
      mscratch_r <= 32'h0000_0000;
      mepc_r     <= 32'h0000_0000;
      mcause_r   <= 32'h0000_0000;
      mtval_r    <= 32'h0000_0000;
    end else begin
      if (we_mstatus_s)  mstatus_r  <= masked_write(val_csr_i, MSTATUS_WMASK, MSTATUS_FIXED);
      if (we_mie_s)      mie_r      <= masked_write(val_csr_i, MIE_WMASK, 32'h0000_0000);
      if (we_mtvec_s)    mtvec_r    <= masked_write(val_csr_i, ALIGN4_WMASK, 32'h0000_0000);
      if (we_mscratch_s) mscratch_r <= val_csr_i;
      if (we_mepc_s)     mepc_r     <= masked_write(val_csr_i, ALIGN4_WMASK, 32'h0000_0000);
      if (we_mcause_s)   mcause_r   <= val_csr_i;
      if (we_mtval_s)    mtval_r    <= val_csr_i;
    end
  end

  // Cycle counter: always counting out of reset
  rv32im_csr_counter64 #(.XLEN(API_XLEN)) u_mcycle (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .inc_en_i  (1'b1),
    .wr_lo_i   (we_mcycle_s),
    .wr_hi_i   (we_mcycleh_s),
    .wr_data_i (val_csr_i),
    .count_o   (mcycle_s)
  );

  // Retired-instruction counter: no retire source inside this block
  rv32im_csr_counter64 #(.XLEN(API_XLEN)) u_minstret (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .inc_en_i  (1'b0),
    .wr_lo_i   (we_minstret_s),
    .wr_hi_i   (we_minstreth_s),
    .wr_data_i (val_csr_i),
    .count_o   (minstret_s)
  );

  // Read mux on current state; same-cycle writes are not forwarded
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (csr_addr_i)
      CSR_MSTATUS:                rdata_s = mstatus_r;
      CSR_MISA:                   rdata_s = MISA_VALUE;
      CSR_MIE:                    rdata_s = mie_r;
      CSR_MIP:                    rdata_s = 32'h0000_0000;
      CSR_MTVEC:                  rdata_s = mtvec_r;
      CSR_MSCRATCH:               rdata_s = mscratch_r;
      CSR_MEPC:                   rdata_s = mepc_r;
      CSR_MCAUSE:                 rdata_s = mcause_r;
      CSR_MTVAL:                  rdata_s = mtval_r;
      CSR_MCYCLE, CSR_CYCLE:      rdata_s = mcycle_s[API_XLEN-1:0];
      CSR_MCYCLEH, CSR_CYCLEH:    rdata_s = mcycle_s[2*API_XLEN-1:API_XLEN];
      CSR_MINSTRET, CSR_INSTRET:  rdata_s = minstret_s[API_XLEN-1:0];
      CSR_MINSTRETH, CSR_INSTRETH: rdata_s = minstret_s[2*API_XLEN-1:API_XLEN];
      default:                    rdata_s = 32'h0000_0000;
    endcase
  end

  assign val_csr_o         = csr_read_en_i ? rdata_s : 32'h0000_0000;
  assign csr_status_o      = mstatus_r;
  assign priviledge_mode_o = PRIV_M;

endmodule

// File: tb/tb_rv32im_csr_regfile.sv
// Directed bench for rv32im_csr_regfile. Inputs change 1 ns after a rising
// edge; combinational outputs are sampled a further 1 ns later.
module tb_rv32im_csr_regfile;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [11:0] csr_addr_i;
  logic [31:0] val_csr_i;
  logic        csr_write_en_i;
  logic        csr_read_en_i;
  logic [31:0] val_csr_o;
  logic [31:0] csr_status_o;
  logic [1:0]  priviledge_mode_o;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  logic [63:0] exp_cyc = 64'd0;

  rv32im_csr_regfile dut (
    .clk_i             (clk_i),
    .rst_n_i           (rst_n_i),
    .csr_addr_i        (csr_addr_i),
    .val_csr_i         (val_csr_i),
    .csr_write_en_i    (csr_write_en_i),
    .csr_read_en_i     (csr_read_en_i),
    .val_csr_o         (val_csr_o),
    .csr_status_o      (csr_status_o),
    .priviledge_mode_o (priviledge_mode_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp_v);
    end
  endtask

  // One rising edge; the expected cycle count follows reset and counting.
  task automatic tick;
    @(posedge clk_i);
    if (rst_n_i) exp_cyc = exp_cyc + 64'd1;
    else exp_cyc = 64'd0;
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input string tag, input logic [31:0] exp_v);
    csr_addr_i = a;
    csr_read_en_i = 1'b1;
    #1;
    check(tag, val_csr_o, exp_v);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_addr_i = a;
    val_csr_i = d;
    csr_write_en_i = 1'b1;
    tick();
    csr_write_en_i = 1'b0;
  endtask

  initial begin
    rst_n_i = 1'b0;
    csr_addr_i = 12'h000;
    val_csr_i = 32'h0;
    csr_write_en_i = 1'b0;
    csr_read_en_i = 1'b0;
    #1;
    tick();
    rst_n_i = 1'b1;

    // Reset state
    rd(12'hB00, "mcycle_first", 32'h0000_0000);
    rd(12'h300, "mstatus_rst", 32'h0000_1800);
    check("status_rst", csr_status_o, 32'h0000_1800);
    check("priv_m", {30'h0, priviledge_mode_o}, 32'h0000_0003);
    rd(12'h301, "misa", 32'h4000_1100);

    // mstatus masking; same-cycle read shows old value
    csr_addr_i = 12'h300; val_csr_i = 32'hF000_0000; csr_write_en_i = 1'b1;
    #1;
    check("mstatus_same_cycle", val_csr_o, 32'h0000_1800);
    tick();
    csr_write_en_i = 1'b0;
    rd(12'h300, "mstatus_hi_ignored", 32'h0000_1800);
    wr(12'h300, 32'h0000_0088);
    rd(12'h300, "mstatus_mie_mpie", 32'h0000_1888);
    check("status_out", csr_status_o, 32'h0000_1888);

    // mcycle counts one per edge
    rd(12'hB00, "mcycle_a", exp_cyc[31:0]);
    check("mcycle_a_const", exp_cyc[31:0], 32'd2);
    tick();
    rd(12'hB00, "mcycle_b", 32'd3);
    tick();
    rd(12'hB00, "mcycle_c", 32'd4);

    // Masked trap registers
    wr(12'h304, 32'hFFFF_FFFF);
    rd(12'h304, "mie_mask", 32'h0000_0888);
    wr(12'h305, 32'hFFFF_FFFF);
    rd(12'h305, "mtvec_align", 32'hFFFF_FFFC);
    wr(12'h301, 32'h1234_5678);
    rd(12'h301, "misa_ro", 32'h4000_1100);

    // mscratch write timing and read enable gating
    csr_addr_i = 12'h340; val_csr_i = 32'hDEAD_BEEF; csr_write_en_i = 1'b1; csr_read_en_i = 1'b1;
    #1;
    check("mscratch_old", val_csr_o, 32'h0000_0000);
    tick();
    csr_write_en_i = 1'b0;
    rd(12'h340, "mscratch_new", 32'hDEAD_BEEF);
    csr_read_en_i = 1'b0;
    #1;
    check("read_disabled", val_csr_o, 32'h0000_0000);
    check("status_no_re", csr_status_o, 32'h0000_1888);

    // Protected and unimplemented addresses
    wr(12'hC00, 32'h0000_1234);
    wr(12'h7C0, 32'h0000_1234);
    rd(12'h7C0, "unimpl_zero", 32'h0000_0000);
    rd(12'hC00, "cycle_shadow", exp_cyc[31:0]);
    rd(12'hB00, "mcycle_unaffected", exp_cyc[31:0]);

    // mcycle low write then carry into mcycleh
    wr(12'hB00, 32'hFFFF_FFFF);
    exp_cyc = 64'h0000_0000_FFFF_FFFF;
    rd(12'hB00, "mcycle_written", 32'hFFFF_FFFF);
    rd(12'hB80, "mcycleh_held", 32'h0000_0000);
    tick();
    rd(12'hB00, "mcycle_wrap", 32'h0000_0000);
    rd(12'hB80, "mcycleh_carry", 32'h0000_0001);
    rd(12'hC80, "cycleh_shadow", 32'h0000_0001);

    // minstret halves and shadows, mepc, mhartid
    wr(12'hB02, 32'h0000_0055);
    wr(12'hB82, 32'h0000_00AA);
    rd(12'hB02, "minstret", 32'h0000_0055);
    rd(12'hC82, "instreth_shadow", 32'h0000_00AA);
    wr(12'h341, 32'h8000_0003);
    rd(12'h341, "mepc_align", 32'h8000_0000);
    rd(12'hF14, "mhartid", 32'h0000_0000);

    // Mid-run reset discards a pending write
    csr_addr_i = 12'h340; val_csr_i = 32'h1111_1111; csr_write_en_i = 1'b1;
    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    csr_write_en_i = 1'b0;
    rd(12'hB00, "mcycle_after_rst", 32'h0000_0000);
    rd(12'hB80, "mcycleh_after_rst", 32'h0000_0000);
    rd(12'h340, "mscratch_after_rst", 32'h0000_0000);
    rd(12'h300, "mstatus_after_rst", 32'h0000_1800);
    tick();
    rd(12'hB00, "mcycle_first_edge", 32'h0000_0001);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
